// File: rtl/vote_pkg.sv
// Shared constants and types for the vote result read-out path.
// Holds the frame layout, FSM encoding and candidate index type.
package vote_pkg;

   localparam logic [7:0] FRAME_HDR = 8'hA5;
   localparam int unsigned FRAME_LEN = 7;

   typedef logic [1:0] state_t;
   localparam state_t StIdle = 2'd0;
   localparam state_t StLoad = 2'd1;
   localparam state_t StSend = 2'd2;

   typedef logic [1:0] cand_idx_t;

endpackage

// File: rtl/vote_winner_select.sv
// Combinational winner picker over four tallies: highest count wins,
// lowest index wins an equal maximum and flags a tie.
module vote_winner_select
   import vote_pkg::*;
(
   input  logic [7:0] c1_count,
   input  logic [7:0] c2_count,
   input  logic [7:0] c3_count,
   input  logic [7:0] c4_count,
   output cand_idx_t  winner,
   output logic       tie
);

   logic [7:0] counts [4];
   logic [7:0] max_count;

   always_comb begin
      counts[0] = c1_count;
      counts[1] = c2_count;
      counts[2] = c3_count;
      counts[3] = c4_count;
      winner    = '0;
      max_count = counts[0];
      // Strict compare keeps the lowest index on equal counts.
      for (int i = 1; i < 4; i++) begin
         if (counts[i] > max_count) begin
            max_count = counts[i];
            winner    = cand_idx_t'(i);
         end
      end
      tie = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if ((cand_idx_t'(i) != winner) && (counts[i] == max_count)) begin
            tie = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vote_result_reader.sv
// Snapshots the four tallies on a result-mode start, picks the winner and
// streams a 7-byte result frame over a valid/ready byte interface.
module vote_result_reader
   import vote_pkg::*;
#(
   parameter int unsigned COUNT_W   = 8,
   parameter logic [7:0]  FRAME_HDR = vote_pkg::FRAME_HDR
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               mode,
   input  logic               start,
   input  logic [COUNT_W-1:0] cand1_vote,
   input  logic [COUNT_W-1:0] cand2_vote,
   input  logic [COUNT_W-1:0] cand3_vote,
   input  logic [COUNT_W-1:0] cand4_vote,
   output logic [COUNT_W-1:0] tx_data,
   output logic               tx_valid,
   input  logic               tx_ready,
   output logic               busy,
   output logic [1:0]         winner,
   output logic               tie,
   output logic               winner_valid
);

   localparam logic [2:0] LastIdx = 3'(FRAME_LEN - 1);

   state_t       state_q;
   logic [2:0]   idx_q;
   logic [7:0]   snap_q [4];
   cand_idx_t    winner_q;
   logic         tie_q;
   logic         winner_valid_q;
   cand_idx_t    sel_winner;
   logic         sel_tie;
   logic [7:0]   result_byte;
   logic [7:0]   checksum;
   logic [7:0]   frame_byte;

   vote_winner_select u_winner_select (
      .c1_count (snap_q[0]),
      .c2_count (snap_q[1]),
      .c3_count (snap_q[2]),
      .c4_count (snap_q[3]),
      .winner   (sel_winner),
      .tie      (sel_tie)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         idx_q          <= '0;
         snap_q         <= '{default: '0};
         winner_q       <= '0;
         tie_q          <= 1'b0;
         winner_valid_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start && mode) begin
                  snap_q[0]      <= cand1_vote;
                  snap_q[1]      <= cand2_vote;
                  snap_q[2]      <= cand3_vote;
                  snap_q[3]      <= cand4_vote;
                  winner_valid_q <= 1'b0;
                  state_q        <= StLoad;
               end
            end
            StLoad: begin
               winner_q       <= sel_winner;
               tie_q          <= sel_tie;
               winner_valid_q <= 1'b1;
               idx_q          <= '0;
               state_q        <= StSend;
            end
            StSend: begin
               if (tx_ready) begin
                  if (idx_q == LastIdx) begin
                     idx_q   <= '0;
                     state_q <= StIdle;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      result_byte = {tie_q, 5'b0, winner_q};
      checksum    = FRAME_HDR ^ snap_q[0] ^ snap_q[1] ^ snap_q[2] ^ snap_q[3] ^ result_byte;
      case (idx_q)
         3'd0:    frame_byte = FRAME_HDR;
         3'd1:    frame_byte = snap_q[0];
         3'd2:    frame_byte = snap_q[1];
         3'd3:    frame_byte = snap_q[2];
         3'd4:    frame_byte = snap_q[3];
         3'd5:    frame_byte = result_byte;
         3'd6:    frame_byte = checksum;
         default: frame_byte = '0;
      endcase
   end

   // Outputs decode straight from state so a reset drops tx_valid immediately.
   assign tx_valid     = (state_q == StSend);
   assign tx_data      = tx_valid ? frame_byte : '0;
   assign busy         = (state_q == StLoad) || (state_q == StSend);
   assign winner       = winner_q;
   assign tie          = tie_q;
   assign winner_valid = winner_valid_q;

endmodule

// File: tb/tb_vote_result_reader.sv
// Self-checking bench for vote_result_reader: directed and random frames
// compared against a behavioural frame model.
module tb_vote_result_reader;

   logic       clock = 1'b0;
   logic       reset;
   logic       mode;
   logic       start;
   logic       tx_ready;
   logic [7:0] c1, c2, c3, c4;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       busy;
   logic [1:0] winner;
   logic       tie;
   logic       winner_valid;

   int checks   = 0;
   int failures = 0;
   logic [7:0] got [7];

   vote_result_reader dut (
      .clock        (clock),
      .reset        (reset),
      .mode         (mode),
      .start        (start),
      .cand1_vote   (c1),
      .cand2_vote   (c2),
      .cand3_vote   (c3),
      .cand4_vote   (c4),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .busy         (busy),
      .winner       (winner),
      .tie          (tie),
      .winner_valid (winner_valid)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected frame from the rules: max count, first index holding it, tie if shared.
   task automatic model(input logic [3:0][7:0] cnt, output logic [6:0][7:0] f,
                        output logic [1:0] w, output logic t);
      int mx  = -1;
      int neq = 0;
      w = 2'd0;
      for (int i = 0; i < 4; i++) if (int'(cnt[i]) > mx) mx = int'(cnt[i]);
      for (int i = 0; i < 4; i++) begin
         if (int'(cnt[i]) == mx) begin
            if (neq == 0) w = 2'(i);
            neq++;
         end
      end
      t    = (neq > 1);
      f[0] = 8'hA5;
      for (int i = 0; i < 4; i++) f[i+1] = cnt[i];
      f[5] = {t, 5'b0, w};
      f[6] = 8'h00;
      for (int i = 0; i < 6; i++) f[6] = f[6] ^ f[i];
   endtask

   task automatic send_frame(input logic [3:0][7:0] cnt, input bit rnd_ready,
                             input int stall_at, input bit disturb);
      logic [6:0][7:0] ef;
      logic [1:0]      ew;
      logic            et;
      int              n = 0;
      int              cyc = 0;
      int              stall_left = 10;
      bit              prev_stall = 0;
      bit              pulsed = 0;
      logic [7:0]      prev_data = 8'h00;
      model(cnt, ef, ew, et);
      @(negedge clock);
      c1 = cnt[0]; c2 = cnt[1]; c3 = cnt[2]; c4 = cnt[3];
      start = 1'b1; mode = 1'b1; tx_ready = 1'b0;
      @(negedge clock);
      start = 1'b0;
      chk("load_tx_valid", tx_valid, 1'b0);
      chk("load_busy", busy, 1'b1);
      chk("load_winner_valid", winner_valid, 1'b0);
      if (disturb) mode = 1'b0;
      @(negedge clock);
      chk("latency_tx_valid", tx_valid, 1'b1);
      while (n < 7 && cyc < 400) begin
         if (prev_stall) begin
            chk("stall_data_stable", tx_data, prev_data);
            chk("stall_valid_held", tx_valid, 1'b1);
         end
         if (n == stall_at && stall_left > 0) begin
            tx_ready = 1'b0;
            stall_left--;
         end else begin
            tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (tx_valid && tx_ready) begin
            got[n] = tx_data;
            n++;
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         if (disturb) begin
            start = (n == 3) && !pulsed;
            if (start) pulsed = 1;
            c1 = 8'd9; c2 = 8'd9; c3 = 8'd9; c4 = 8'd9;
         end
         @(negedge clock);
         cyc++;
      end
      tx_ready = 1'b0;
      start    = 1'b0;
      chk("frame_byte_count", 32'(n), 32'd7);
      chk("end_tx_valid", tx_valid, 1'b0);
      chk("end_busy", busy, 1'b0);
      for (int i = 0; i < 7; i++) chk($sformatf("frame_byte%0d", i), got[i], ef[i]);
      chk("winner", winner, ew);
      chk("tie", tie, et);
      chk("winner_valid", winner_valid, 1'b1);
      if (disturb) begin
         for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("no_second_frame", {tx_valid, busy}, 2'b00);
         end
         chk("winner_held", winner, ew);
         mode = 1'b1;
      end
   endtask

   initial begin
      reset = 1'b1; mode = 1'b0; start = 1'b0; tx_ready = 1'b0;
      c1 = 8'd0; c2 = 8'd0; c3 = 8'd0; c4 = 8'd0;
      repeat (2) @(negedge clock);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_tx_valid", tx_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_winner", winner, 2'd0);
      chk("rst_tie", tie, 1'b0);
      chk("rst_winner_valid", winner_valid, 1'b0);
      reset = 1'b0;

      // start without result mode is ignored
      start = 1'b1; mode = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         chk("mode0_idle", {tx_valid, busy}, 2'b00);
      end
      start = 1'b0;

      send_frame({8'd7, 8'd2, 8'd7, 8'd3}, 1'b0, -1, 1'b0);
      chk("tie_frame_result", got[5], 8'h81);
      chk("tie_frame_checksum", got[6], 8'h25);
      send_frame({8'd0, 8'd0, 8'd0, 8'd10}, 1'b0, -1, 1'b0);
      chk("solo_frame_checksum", got[6], 8'hAF);
      send_frame({8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, -1, 1'b0);
      chk("zero_frame_result", got[5], 8'h80);

      // backpressure with a long stall, counts and start disturbed mid-frame
      send_frame({8'd7, 8'd2, 8'd7, 8'd3}, 1'b1, 2, 1'b1);

      // reset while transmitting byte index 3
      @(negedge clock);
      c1 = 8'd3; c2 = 8'd7; c3 = 8'd2; c4 = 8'd7;
      start = 1'b1; mode = 1'b1;
      @(negedge clock);
      start = 1'b0; tx_ready = 1'b1;
      repeat (4) @(negedge clock);
      chk("pre_reset_byte3", tx_data, 8'h02);
      #2 reset = 1'b1;
      #1;
      chk("midreset_tx_valid", tx_valid, 1'b0);
      chk("midreset_busy", busy, 1'b0);
      chk("midreset_winner_valid", winner_valid, 1'b0);
      @(negedge clock);
      reset = 1'b0; tx_ready = 1'b0;
      send_frame({8'd7, 8'd2, 8'd7, 8'd3}, 1'b0, -1, 1'b0);

      for (int k = 0; k < 5; k++) begin
         send_frame({8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                     8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))},
                    1'b1, int'($urandom_range(0, 6)), 1'b0);
      end
      send_frame({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, 1'b1, -1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
